wishbone_arbiter2: RTL
======================

# wishbone_arbiter2

Two-master Wishbone arbiter that shares one single-port Wishbone slave, such as the on-chip RAM or LED peripheral. Its typical masters are the RISC-V core's instruction-fetch port (M0) and data port (M1). It grants the bus with round-robin fairness and holds the grant for the whole CYC burst. It routes strobe, address, write data and ACK between the current owner and the slave. A watchdog raises ERR to the owner if the slave fails to ACK.

## Interface
- ADDRESS_WIDTH, 8, address bus width
- DATA_WIDTH, 8, data bus width
- TIMEOUT, 15, cycles a strobe may wait for ACK before ERR (minimum 2)

- CLK_I  input  1  system clock; all state changes on rising edge
- RST_I  input  1  reset, synchronous, active-high
- M0_CYC_I, M1_CYC_I  input  1  master bus request / bus hold
- M0_STB_I, M1_STB_I  input  1  master transfer strobe
- M0_WE_I, M1_WE_I  input  1  master write enable
- M0_ADR_I, M1_ADR_I  input  ADDRESS_WIDTH  master address
- M0_DAT_I, M1_DAT_I  input  DATA_WIDTH  master write data
- M0_DAT_O, M1_DAT_O  output  DATA_WIDTH  read data; S_DAT_I when owner, else 0
- M0_ACK_O, M1_ACK_O  output  1  transfer acknowledge to the owner
- M0_ERR_O, M1_ERR_O  output  1  timeout error pulse to the owner
- S_STB_O  output  1  slave strobe
- S_WE_O  output  1  slave write enable
- S_ADR_O  output  ADDRESS_WIDTH  slave address
- S_DAT_O  output  DATA_WIDTH  slave write data
- S_DAT_I  input  DATA_WIDTH  slave read data
- S_ACK_I  input  1  slave acknowledge; the slave ACKs one cycle after sampling STB
- GNT_O  output  2  one-hot grant (bit0 = M0, bit1 = M1); 00 when idle

## Operation
**States**
- IDLE, OWN0, OWN1.
- GNT_O is 01 in OWN0, 10 in OWN1, 00 in IDLE.

**Priority pointer**
- A 1-bit register named `last`, recording the most recently granted master.
- Reset value is 1, so M0 wins the first tie.

**Transitions**
- IDLE:
  - Only one CYC high → OWNx for that master.
  - Both high → the master not equal to `last`.
  - Neither high → stay in IDLE.
- OWNx while Mx_CYC_I is high → stay in OWNx. Grant is never preempted.
- OWNx with Mx_CYC_I low:
  - Other master's CYC high → go directly to OWNy.
  - Otherwise → IDLE.
- Entering OWNx sets `last` = x.

**Routing (combinational from state)**
- In OWNx: S_STB_O, S_WE_O, S_ADR_O and S_DAT_O follow master x's inputs, with S_STB_O = Mx_STB_I & Mx_CYC_I.
- In IDLE: all slave outputs are 0.
- Mx_DAT_O = S_DAT_I when owner, else 0.
- Mx_ACK_O = S_ACK_I & owner & !first. `first` is high only in the first cycle after any state change.
- Masking ACK with `first` discards a stale ACK belonging to the previous owner.

**Watchdog**
- Counter of width $clog2(TIMEOUT+1).
- Increments each cycle that S_STB_O is high and the owner's ACK_O is low.
- Clears on ACK, on S_STB_O low, and on any state change.
- When the counter equals TIMEOUT-1 and no ACK arrives that cycle:
  - Mx_ERR_O goes high for exactly the next cycle (registered).
  - The counter clears.
  - The grant is kept; the master is expected to drop STB or CYC.
- ACK and timeout in the same cycle → ACK wins and no ERR is raised.

**Reset**
- RST_I high at any edge, including mid-transfer:
  - Next state IDLE, `last` = 1, counter 0, ERR registers 0.
- Reset values of all outputs:
  - S_STB_O = 0, S_WE_O = 0, S_ADR_O = 0, S_DAT_O = 0.
  - M0/M1 ACK_O = 0, ERR_O = 0, DAT_O = 0.
  - GNT_O = 00.

## Timing
- Grant latency: CYC rises in cycle n from IDLE → owner state in cycle n+1, with S_STB_O visible in n+1.
- With the one-cycle slave, ACK_O is high in cycle n+2. The first transfer of a burst therefore takes 3 cycles from the CYC request.
- Back-to-back transfers within a held grant: one transfer every 2 cycles (STB high, ACK, STB drop).
  - A master holding STB after ACK receives a repeated ACK in the next cycle and repeats the access.
  - The master must drop STB on ACK.
- Handover: owner drops CYC in cycle k → other master is owner in k+1, and its ACK is masked in k+1.
- ERR: with STB held and no ACK, Mx_ERR_O is high exactly TIMEOUT cycles after S_STB_O first rose.

## Test plan
1. **Reset.** Assert RST_I for 2 cycles with both CYC high → all outputs 0 and GNT_O = 00 during reset. The first grant after reset goes to M0 (GNT_O = 01).
2. **Single read.** M1 CYC/STB, ADR = 0x10, slave returns 0xA5 → S_ADR_O = 0x10 in cycle 1, M1_ACK_O and M1_DAT_O = 0xA5 in cycle 2. M0_ACK_O stays 0 and M0_DAT_O = 0.
3. **Contention and round-robin.** Both masters request continuously, each dropping CYC after one write → grants alternate 01, 10, 01, 10. Slave sees M0_DAT_I = 0x11 and M1_DAT_I = 0x22 in alternate transfers.
4. **Stale-ACK masking.** M0 drops CYC in the same cycle its ACK-producing STB was sampled, while M1 is requesting → the S_ACK_I pulse in M1's first owned cycle is not seen on M1_ACK_O.
5. **Timeout.** TIMEOUT = 4, S_ACK_I tied 0, M0 holds STB → M0_ERR_O is a 1-cycle pulse 4 cycles after S_STB_O rose, then repeats every 4 cycles while STB stays high. M1_ERR_O stays 0.
6. **Reset mid-burst.** RST_I asserted while OWN1 with STB high → at the next edge GNT_O = 00, S_STB_O = 0 and the counter is cleared. A later tie is granted to M0.

Source files
------------

// File: rtl/wishbone_arbiter2.sv
// Two-master round-robin Wishbone arbiter sharing one single-port slave.
// The grant is held for the whole CYC burst, and a watchdog raises ERR when the slave does not ACK.
module wishbone_arbiter2 #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT       = 15
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     M0_CYC_I,
    input  logic                     M0_STB_I,
    input  logic                     M0_WE_I,
    input  logic [ADDRESS_WIDTH-1:0] M0_ADR_I,
    input  logic [DATA_WIDTH-1:0]    M0_DAT_I,
    output logic [DATA_WIDTH-1:0]    M0_DAT_O,
    output logic                     M0_ACK_O,
    output logic                     M0_ERR_O,
    input  logic                     M1_CYC_I,
    input  logic                     M1_STB_I,
    input  logic                     M1_WE_I,
    input  logic [ADDRESS_WIDTH-1:0] M1_ADR_I,
    input  logic [DATA_WIDTH-1:0]    M1_DAT_I,
    output logic [DATA_WIDTH-1:0]    M1_DAT_O,
    output logic                     M1_ACK_O,
    output logic                     M1_ERR_O,
    output logic                     S_STB_O,
    output logic                     S_WE_O,
    output logic [ADDRESS_WIDTH-1:0] S_ADR_O,
    output logic [DATA_WIDTH-1:0]    S_DAT_O,
    input  logic [DATA_WIDTH-1:0]    S_DAT_I,
    input  logic                     S_ACK_I,
    output logic [1:0]               GNT_O
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_first;
    logic            r_err0;
    logic            r_err1;
    logic [1:0]      r_gnt;
    logic [CW-1:0]   r_cnt;
    logic            w_own0;
    logic            w_own1;
    logic            w_change;
    logic            w_ack;

    assign w_own0   = (r_state == OWN0);
    assign w_own1   = (r_state == OWN1);
    assign w_change = (w_next != r_state);

    // On a tie out of IDLE, the master that was not granted last wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    w_next = r_last ? OWN0 : OWN1;
                end else if (M0_CYC_I) begin
                    w_next = OWN0;
                end else if (M1_CYC_I) begin
                    w_next = OWN1;
                end
            end
            OWN0: begin
                if (!M0_CYC_I) begin
                    w_next = M1_CYC_I ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!M1_CYC_I) begin
                    w_next = M0_CYC_I ? OWN0 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        if (w_own0) begin
            S_STB_O = M0_STB_I & M0_CYC_I;
            S_WE_O  = M0_WE_I;
            S_ADR_O = M0_ADR_I;
            S_DAT_O = M0_DAT_I;
        end else if (w_own1) begin
            S_STB_O = M1_STB_I & M1_CYC_I;
            S_WE_O  = M1_WE_I;
            S_ADR_O = M1_ADR_I;
            S_DAT_O = M1_DAT_I;
        end
    end

    // An ACK arriving in the first owned cycle belongs to the previous owner.
    assign w_ack    = S_ACK_I & (w_own0 | w_own1) & ~r_first;
    assign M0_ACK_O = S_ACK_I & w_own0 & ~r_first;
    assign M1_ACK_O = S_ACK_I & w_own1 & ~r_first;
    assign M0_DAT_O = w_own0 ? S_DAT_I : '0;
    assign M1_DAT_O = w_own1 ? S_DAT_I : '0;
    assign M0_ERR_O = r_err0;
    assign M1_ERR_O = r_err1;
    assign GNT_O    = r_gnt;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_first <= 1'b0;
            r_gnt   <= 2'b00;
            r_cnt   <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= w_change;
            r_gnt   <= {w_next == OWN1, w_next == OWN0};
            if (w_change && (w_next == OWN0)) begin
                r_last <= 1'b0;
            end else if (w_change && (w_next == OWN1)) begin
                r_last <= 1'b1;
            end
            // A timeout keeps the grant and only pulses ERR to the owner.
            if (w_change || !S_STB_O || w_ack) begin
                r_cnt  <= '0;
                r_err0 <= 1'b0;
                r_err1 <= 1'b0;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                r_cnt  <= '0;
                r_err0 <= w_own0;
                r_err1 <= w_own1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_err0 <= 1'b0;
                r_err1 <= 1'b0;
            end
        end
    end

endmodule
